// File: rtl/vending_pkg.sv
// Shared types for the ticket-machine payout path: coin denominations and
// the payout FSM state encoding.
package vending_pkg;

    typedef logic [1:0] denom_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // Coin value per denomination index, largest first so index order is greedy order.
    localparam logic [7:0] DENOM_VALUE [4] = '{8'd50, 8'd10, 8'd5, 8'd1};

    function automatic logic [7:0] denom_value(input denom_t d);
        return DENOM_VALUE[d];
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy pick: lowest denomination index whose value fits the
// amount still owed and whose inventory is not empty.
module coin_select
    import vending_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] i_owed,
    input  logic [3:0]       i_inv_nz,
    output logic             o_found,
    output denom_t           o_denom
);

    always_comb begin
        o_found = 1'b0;
        o_denom = '0;
        // Walk from smallest coin to largest so the last hit is the largest coin.
        for (int d = 3; d >= 0; d--) begin
            if (i_inv_nz[d] && (16'(denom_value(denom_t'(d))) <= 16'(i_owed))) begin
                o_found = 1'b1;
                o_denom = denom_t'(d);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays a requested amount one coin per hopper handshake,
// tracking per-denomination inventory. Optional audit counter: AUDIT_COUNTER_EN.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W    = 8,
    parameter int INV_W    = 6,
    parameter int INIT_CNT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic             coin_valid,
    output denom_t           coin_denom,
    input  logic             coin_ready,
    input  logic             refill,
    input  denom_t           refill_denom,
    input  logic [INV_W-1:0] refill_count,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] owed,
    output logic [15:0]      total_paid,
    output state_t           dbg_state
);

    localparam int INV_MAX    = (1 << INV_W) - 1;
    localparam int INIT_CLAMP = (INIT_CNT > INV_MAX) ? INV_MAX : INIT_CNT;
    localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_CLAMP);
    localparam logic [INV_W:0]   INV_SAT  = (INV_W+1)'(INV_MAX);

    // Handshakes: a request is taken on req_valid & req_ready (ready only in IDLE);
    // a coin is taken on coin_valid & coin_ready, and coin_denom is frozen until then.
    state_t           r_state;
    logic             r_req_ready;
    logic             r_coin_valid;
    logic             r_done;
    logic             r_short;
    denom_t           r_denom;
    logic [AMT_W-1:0] r_owed;
    logic [INV_W-1:0] r_inv [4];

    logic [INV_W-1:0] w_inv_next [4];
    logic [INV_W:0]   w_sum;
    logic [3:0]       w_inv_nz;
    logic             w_found;
    denom_t           w_pick;
    logic             w_take;
    logic [AMT_W-1:0] w_coin_val;

    assign w_take     = r_coin_valid & coin_ready;
    assign w_coin_val = AMT_W'(denom_value(r_denom));

    coin_select #(
        .AMT_W (AMT_W)
    ) u_coin_select (
        .i_owed   (r_owed),
        .i_inv_nz (w_inv_nz),
        .o_found  (w_found),
        .o_denom  (w_pick)
    );

    // Refill and a same-cycle coin take combine before saturating at the top.
    always_comb begin
        w_sum = '0;
        for (int d = 0; d < 4; d++) begin
            w_inv_nz[d] = (r_inv[d] != '0);
            w_sum = {1'b0, r_inv[d]};
            if (refill && (refill_denom == denom_t'(d))) begin
                w_sum = w_sum + {1'b0, refill_count};
            end
            if (w_take && (r_denom == denom_t'(d))) begin
                w_sum = w_sum - (INV_W+1)'(1);
            end
            w_inv_next[d] = (w_sum > INV_SAT) ? INV_SAT[INV_W-1:0] : w_sum[INV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                r_inv[d] <= INV_INIT;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                r_inv[d] <= w_inv_next[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_coin_valid <= 1'b0;
            r_done       <= 1'b0;
            r_short      <= 1'b0;
            r_denom      <= '0;
            r_owed       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_owed      <= req_amount;
                        r_short     <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (w_found) begin
                        r_denom      <= w_pick;
                        r_coin_valid <= 1'b1;
                        r_state      <= DISPENSE;
                    end else begin
                        r_short <= (r_owed != '0);
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                DISPENSE: begin
                    if (coin_ready) begin
                        r_owed       <= r_owed - w_coin_val;
                        r_coin_valid <= 1'b0;
                        r_state      <= SELECT;
                    end
                end
                FINISH: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef AUDIT_COUNTER_EN
    logic [15:0] r_total;
    logic [16:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total} + 17'(denom_value(r_denom));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= '0;
        end else if (w_take) begin
            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    assign total_paid = r_total;
`else
    assign total_paid = 16'd0;
`endif

    assign req_ready  = r_req_ready;
    assign busy       = ~r_req_ready;
    assign coin_valid = r_coin_valid;
    assign coin_denom = r_denom;
    assign done       = r_done;
    assign short      = r_short;
    assign owed       = r_owed;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded bench for change_dispenser: a greedy payout model predicts the coin
// stream and final result of every request; a monitor compares what the DUT delivers.
module tb_change_dispenser;
    import vending_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_amount = '0;
    logic        coin_valid;
    denom_t      coin_denom;
    logic        coin_ready = 1'b1;
    logic        refill = 1'b0;
    denom_t      refill_denom = '0;
    logic [5:0]  refill_count = '0;
    logic        busy;
    logic        done;
    logic        short;
    logic [7:0]  owed;
    logic [15:0] total_paid;
    state_t      dbg_state;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_amount   (req_amount),
        .coin_valid   (coin_valid),
        .coin_denom   (coin_denom),
        .coin_ready   (coin_ready),
        .refill       (refill),
        .refill_denom (refill_denom),
        .refill_count (refill_count),
        .busy         (busy),
        .done         (done),
        .short        (short),
        .owed         (owed),
        .total_paid   (total_paid),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: driven by the test
    logic [1:0]  exp_q[$];
    logic [24:0] res_q[$];   // {short, owed, total_paid}
    int minv[4];
    int mtotal;
    int dval[4] = '{50, 10, 5, 1};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int d = 0; d < 4; d++) minv[d] = 20;
        mtotal = 0;
    endfunction

    function automatic void model_refill(input int d, input int c);
        minv[d] = (minv[d] + c > 63) ? 63 : minv[d] + c;
    endfunction

    function automatic void model_request(input int amt);
        int a;
        logic [24:0] r;
        a = amt;
        for (int d = 0; d < 4; d++) begin
            while (a >= dval[d] && minv[d] > 0) begin
                exp_q.push_back(2'(d));
                a = a - dval[d];
                minv[d] = minv[d] - 1;
                mtotal = (mtotal + dval[d] > 65535) ? 65535 : mtotal + dval[d];
            end
        end
`ifdef AUDIT_COUNTER_EN
        r = {a != 0, 8'(a), 16'(mtotal)};
`else
        r = {a != 0, 8'(a), 16'd0};
`endif
        res_q.push_back(r);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic   prev_stall = 1'b0;
    denom_t prev_denom = '0;

    initial forever begin
        logic [1:0]  e;
        logic [24:0] r;
        @(negedge clk);
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_coin_valid", int'(coin_valid), 1);
                check("hold_coin_denom", int'(coin_denom), int'(prev_denom));
            end
            if (coin_valid && coin_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_coin: got denom %0d expected none at %0t", coin_denom, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("coin_denom", int'(coin_denom), int'(e));
                end
            end
            if (done) begin
                done_seen++;
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
                end else begin
                    r = res_q.pop_front();
                    check("short", int'(short), int'(r[24]));
                    check("owed", int'(owed), int'(r[23:16]));
                    check("total_paid", int'(total_paid), int'(r[15:0]));
                    check("coins_left_at_done", exp_q.size(), 0);
                end
            end
            prev_stall = coin_valid && !coin_ready;
            prev_denom = coin_denom;
        end
    end

    // ---------------- drivers ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) coin_ready = 1'b1;
        else if (rdy_mode == 1) coin_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input int amt);
        int i;
        model_request(amt);
        req_valid  = 1'b1;
        req_amount = 8'(amt);
        i = 0;
        while (i < 3000) begin
            @(negedge clk);
            if (req_ready) break;
            i++;
        end
        n_cmp++;
        if (i >= 3000) begin
            n_fail++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while (done_seen < target && i < 3000) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (done_seen < target) begin
            n_fail++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_seen, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int amt);
        int t;
        t = done_seen + 1;
        start_req(amt);
        wait_done(t);
    endtask

    task automatic do_refill(input int d, input int c);
        refill       = 1'b1;
        refill_denom = 2'(d);
        refill_count = 6'(c);
        model_refill(d, c);
        tick(1);
        refill = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_coin_valid", int'(coin_valid), 0);
        check("rst_coin_denom", int'(coin_denom), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_owed", int'(owed), 0);
        check("rst_total_paid", int'(total_paid), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        model_reset();
        tick(3);
        reset = 1'b0;
        check_reset_state();

        // Full stock, 87 -> 50,10,10,10,5,1,1
        do_req(87);

        // Zero amount: done on the second cycle after accept, no coin
        t = done_seen + 1;
        start_req(0);
        @(negedge clk);
        check("zero_done_c1", int'(done), 0);
        check("zero_coin_c1", int'(coin_valid), 0);
        @(negedge clk);
        check("zero_done_c2", int'(done), 1);
        check("zero_busy_c2", int'(busy), 1);
        @(negedge clk);
        check("zero_done_c3", int'(done), 0);
        check("zero_ready_c3", int'(req_ready), 1);
        wait_done(t);

        // Saturating refill, then a stalled coin with a same-cycle refill of that denom
        do_refill(0, 63);
        rdy_mode = 2;
        coin_ready = 1'b0;
        t = done_seen + 1;
        start_req(50);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_coin_valid", int'(coin_valid), 1);
            check("stall_coin_denom", int'(coin_denom), 0);
        end
        @(posedge clk);
        #1;
        coin_ready   = 1'b1;
        refill       = 1'b1;
        refill_denom = 2'd0;
        refill_count = 6'd5;
        model_refill(0, 5);
        tick(1);
        coin_ready = 1'b0;
        refill     = 1'b0;
        rdy_mode   = 0;
        wait_done(t);

        // Drain the 50s; the exact count left shows saturation and take+refill math
        for (int k = 0; k < 20 && minv[0] > 0; k++) do_req(250);
        do_refill(0, 20);

        // No 10s: 20 pays as four 5s
        for (int k = 0; k < 20 && minv[1] > 0; k++) do_req((minv[1] >= 4) ? 40 : 10 * minv[1]);
        do_req(20);
        do_refill(1, 20);

        // Single 1 left: 3 pays one coin and comes up short by 2
        for (int k = 0; k < 20 && minv[3] > 1; k++) do_req((minv[3] - 1 >= 4) ? 4 : minv[3] - 1);
        do_req(3);
        do_refill(3, 20);

        // Random traffic with hopper stalls and idle refills
        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 15));
            do_req($urandom_range(0, 255));
        end

        // Reset in the middle of a stalled payout: no done, stock back to initial
        rdy_mode = 2;
        coin_ready = 1'b0;
        start_req(87);
        tick(3);
        reset = 1'b1;
        tick(2);
        exp_q.delete();
        res_q.delete();
        model_reset();
        reset = 1'b0;
        rdy_mode = 0;
        check_reset_state();
        do_req(87);
        do_req(255);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
